axi4l_arbiter2: RTL
===================

Name: axi4l_arbiter2

Overview:
- Two-master, one-slave AXI4-Lite arbiter: shares one peripheral port (e.g. LED/GPIO register slave) between two requesters (e.g. Ibex data port and debug/loader master).
- Whole-transaction granularity, one outstanding transaction, round-robin between masters.
- Sits between the masters and the peripheral decoder; pure pass-through of payload, no buffering of data.

Parameters:
- WRITE_FIRST, 1, when the granted master presents both awvalid and arvalid in IDLE: 1 = write first, 0 = read first.

Ports:
- aclk  input  1  clock, all logic on rising edge.
- areset  input  1  synchronous, active-high reset.
- s0  axi4l_if.slave  -  master 0 side (higher priority immediately after reset).
- s1  axi4l_if.slave  -  master 1 side.
- m  axi4l_if.master  -  shared downstream slave port.
- gnt  output  2  one-hot current grant; 2'b00 in IDLE.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, gnt=00, busy=0, last=1 (so s0 wins the first tie).
  - m.awvalid/wvalid/arvalid/bready/rready = 0.
  - All s*.awready/wready/arready/bvalid/rvalid = 0.
  - s*.bresp/rresp = OKAY, s*.rdata = 0.
- Request of master i: req_i = s_i.awvalid | s_i.arvalid (wvalid alone is not a request).
- IDLE arbitration:
  - One requester: grant it.
  - Both requesting: grant the master != last.
  - Choose WR or RD per WRITE_FIRST when both channels are valid; otherwise the valid one.
  - Grant and state are registered. First forwarded cycle is the cycle after the request is seen, i.e. 1 arbitration bubble per transaction.
  - No outputs are asserted in IDLE.
- States: IDLE, WR, WR_RESP, RD, RD_RESP.
- WR:
  - AW and W channels of the granted master are forwarded combinationally to m (valid, addr, prot, data, strb) and ready is forwarded back.
  - Flags aw_done and w_done are set on the respective m handshake; after set, the channel is gated (m valid = 0, s ready = 0).
  - W may complete before, with, or after AW.
  - When both are done (same-cycle completion included): go to WR_RESP, clear flags.
- WR_RESP:
  - Forward m.bvalid/bresp to the granted master, and that master's bready to m.
  - On the b handshake: go to IDLE, last=granted index.
- RD: forward AR channel; on the ar handshake go to RD_RESP.
- RD_RESP:
  - Forward rvalid/rdata/rresp and rready.
  - On the r handshake: go to IDLE, last=granted index.
- Non-granted master: all readies and valids 0, responses OKAY/0.
  - Its valids stay pending (AXI rule); no drop, no timeout.
- gnt stays constant from grant until the return to IDLE, and busy follows the state.
  - No preemption; the response channel may stall indefinitely.
- A master holding both aw and ar: the second transaction requires re-arbitration. Round-robin applies, so the other master can interleave.
- areset mid-transaction:
  - Next edge forces the reset state. The in-flight transaction is abandoned with no response (system-wide reset assumed).
  - Flags are cleared.
- Stability: all valid/payload outputs toward the slaves are sourced from m.
  - m's compliance implies bvalid/rvalid stable until ready; the arbiter must not break this, because gnt cannot change while a response is pending.

Test Plan:
- s0 write awaddr=0x000, wdata=0x5, strb=0xF, s1 idle:
  - m sees AW/W exactly those values.
  - m returns bresp=OKAY, which appears on s0.
  - gnt=01 for the whole transaction; s1 readies remain 0.
- After reset, same cycle, s0 read 0x000 and s1 write 0x004:
  - s0 is served first (gnt=01).
  - m bresp=SLVERR for s1 is forwarded to s1 only, with gnt=10.
- Both masters issue 4 back-to-back reads each:
  - grant sequence is 0,1,0,1,0,1,0,1.
  - Exactly one IDLE cycle between transactions.
- s1 drives wvalid 2 cycles before awvalid:
  - No grant until awvalid.
  - wready is forwarded only after the grant.
  - WR_RESP is entered only after both handshakes, in either order, including the same cycle.
- s0 holds bready=0 for 3 cycles with s1 requesting:
  - s0.bvalid stays 1 and bresp stays stable.
  - gnt stays 01; s1 is granted only after s0's b handshake.
- areset=1 during RD_RESP with m.rvalid=1:
  - Next cycle: busy=0, gnt=00, all valids and readies 0.
  - The first request after reset goes to s0.

Source files
------------

// File: rtl/axi4l_arbiter2_if.sv
// AXI4-Lite bus bundle shared by the arbiter and its neighbours.
// The master modport drives requests; the slave modport answers them.
interface axi4l_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4l_arbiter2.sv
// Two-master, one-slave AXI4-Lite arbiter.
// Whole transactions are granted round-robin, one outstanding at a time;
// payload is passed straight through, nothing is buffered.
module axi4l_arbiter2 #(
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic       aclk,
  input  logic       areset,
  axi4l_if.slave     s0,
  axi4l_if.slave     s1,
  axi4l_if.master    m,
  output logic [1:0] gnt,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_RESP} state_t;

  state_t state;
  logic   last;
  logic   aw_done;
  logic   w_done;

  logic   sel;
  logic   req0, req1;
  logic   pick, pick_aw, pick_ar, go_write;
  logic   sel_awvalid, sel_wvalid, sel_arvalid, sel_bready, sel_rready;
  logic   fwd_awready, fwd_wready, fwd_arready, fwd_bvalid, fwd_rvalid;
  logic   aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign sel  = gnt[1];
  assign busy = (state != IDLE);

  // Only an address valid counts as a request; a lone wvalid just waits.
  assign req0 = s0.awvalid | s0.arvalid;
  assign req1 = s1.awvalid | s1.arvalid;

  // Round-robin pick: on a tie the master that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) begin
      pick = ~last;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

  assign pick_aw  = pick ? s1.awvalid : s0.awvalid;
  assign pick_ar  = pick ? s1.arvalid : s0.arvalid;
  assign go_write = pick_aw && (WRITE_FIRST || !pick_ar);

  assign sel_awvalid = sel ? s1.awvalid : s0.awvalid;
  assign sel_wvalid  = sel ? s1.wvalid  : s0.wvalid;
  assign sel_arvalid = sel ? s1.arvalid : s0.arvalid;
  assign sel_bready  = sel ? s1.bready  : s0.bready;
  assign sel_rready  = sel ? s1.rready  : s0.rready;

  assign m.awaddr = sel ? s1.awaddr : s0.awaddr;
  assign m.awprot = sel ? s1.awprot : s0.awprot;
  assign m.wdata  = sel ? s1.wdata  : s0.wdata;
  assign m.wstrb  = sel ? s1.wstrb  : s0.wstrb;
  assign m.araddr = sel ? s1.araddr : s0.araddr;
  assign m.arprot = sel ? s1.arprot : s0.arprot;

  // Channel forwarding for the granted master; completed AW/W channels are gated off.
  always_comb begin
    m.awvalid   = 1'b0;
    m.wvalid    = 1'b0;
    m.bready    = 1'b0;
    m.arvalid   = 1'b0;
    m.rready    = 1'b0;
    fwd_awready = 1'b0;
    fwd_wready  = 1'b0;
    fwd_arready = 1'b0;
    fwd_bvalid  = 1'b0;
    fwd_rvalid  = 1'b0;
    case (state)
      WR: begin
        m.awvalid   = sel_awvalid & ~aw_done;
        m.wvalid    = sel_wvalid & ~w_done;
        fwd_awready = m.awready & ~aw_done;
        fwd_wready  = m.wready & ~w_done;
      end
      WR_RESP: begin
        m.bready   = sel_bready;
        fwd_bvalid = m.bvalid;
      end
      RD: begin
        m.arvalid   = sel_arvalid;
        fwd_arready = m.arready;
      end
      RD_RESP: begin
        m.rready   = sel_rready;
        fwd_rvalid = m.rvalid;
      end
      default: begin
      end
    endcase
  end

  assign aw_hs = m.awvalid & m.awready;
  assign w_hs  = m.wvalid & m.wready;
  assign ar_hs = m.arvalid & m.arready;
  assign b_hs  = m.bvalid & m.bready;
  assign r_hs  = m.rvalid & m.rready;

  assign s0.awready = gnt[0] & fwd_awready;
  assign s0.wready  = gnt[0] & fwd_wready;
  assign s0.arready = gnt[0] & fwd_arready;
  assign s0.bvalid  = gnt[0] & fwd_bvalid;
  assign s0.rvalid  = gnt[0] & fwd_rvalid;
  assign s0.bresp   = (gnt[0] && state == WR_RESP) ? m.bresp : 2'b00;
  assign s0.rresp   = (gnt[0] && state == RD_RESP) ? m.rresp : 2'b00;
  assign s0.rdata   = (gnt[0] && state == RD_RESP) ? m.rdata : '0;

  assign s1.awready = gnt[1] & fwd_awready;
  assign s1.wready  = gnt[1] & fwd_wready;
  assign s1.arready = gnt[1] & fwd_arready;
  assign s1.bvalid  = gnt[1] & fwd_bvalid;
  assign s1.rvalid  = gnt[1] & fwd_rvalid;
  assign s1.bresp   = (gnt[1] && state == WR_RESP) ? m.bresp : 2'b00;
  assign s1.rresp   = (gnt[1] && state == RD_RESP) ? m.rresp : 2'b00;
  assign s1.rdata   = (gnt[1] && state == RD_RESP) ? m.rdata : '0;

  // Transaction FSM: grant in IDLE, hold it until the response handshake, then rotate.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      last    <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt <= pick ? 2'b10 : 2'b01;
            if (go_write) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        WR: begin
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            state <= IDLE;
            gnt   <= 2'b00;
            last  <= sel;
          end
        end
        RD: begin
          if (ar_hs) state <= RD_RESP;
        end
        RD_RESP: begin
          if (r_hs) begin
            state <= IDLE;
            gnt   <= 2'b00;
            last  <= sel;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
